uart_bus_loader: RTL and testbench
==================================

Name: uart_bus_loader

Overview:
- UART-driven bus master for the SoC interconnect. Receives command frames on a serial RX pin and issues single-word read/write transactions on a free master port (m2).
- Returns an ACK/NAK byte or read data on a serial TX pin.
- Used to load program RAM and poke peripherals (gpio, pwm, timer) from a host PC without JTAG.
- Asserts a CPU hold while a frame is in progress.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, UART bit rate; bit period DIV = CLK_HZ/BAUD (integer, truncated; 434 at defaults)
TIMEOUT_BITS, 20, inter-byte timeout in bit periods; abort after TIMEOUT_BITS*DIV idle cycles mid-frame

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx_pin  in  1  UART RX, idle high, asynchronous to clk
tx_pin  out  1  UART TX, idle high
m_addr_o  out  32  bus address
m_data_o  out  32  bus write data
m_data_i  in  32  bus read data, valid in the grant cycle
m_req_o  out  1  bus request
m_we_o  out  1  write enable, qualified by m_req_o
m_gnt_i  in  1  grant from interconnect; transaction completes in the cycle req&gnt
cpu_hold_o  out  1  stall request to the core
busy_o  out  1  frame in progress (status / LED)

Behaviour:
- Reset values: tx_pin=1, m_req_o=0, m_we_o=0, m_addr_o=0, m_data_o=0, cpu_hold_o=0, busy_o=0, FSM=IDLE, all counters=0. Reset mid-byte or mid-frame discards everything, with no partial bus transaction.
- RX engine:
  - 2-FF synchronizer on rx_pin.
  - Start is the falling edge of the synchronized line. Re-check at DIV/2; if high, treat as a glitch and return to idle.
  - Then sample 8 data bits LSB-first every DIV cycles, then the stop bit.
  - Stop=1: one-cycle byte_valid with the byte.
  - Stop=0: one-cycle frame_err pulse, no byte_valid.
- Frame format (bytes):
  - 0xA5 sync, then CMD (0x01 write, 0x02 read), then ADDR[7:0], [15:8], [23:16], [31:24].
  - For write: DATA[7:0]..[31:24].
- FSM states:
  - IDLE: wait for 0xA5; other bytes ignored. On 0xA5: busy_o=1, cpu_hold_o=1, go to CMD.
  - CMD: 0x01/0x02 latched, go to ADDR. Any other value: NAK.
  - ADDR: 4 bytes shifted into addr (byte k -> bits 8k+7:8k). After the 4th byte: addr[1:0]!=0 gives NAK; else read goes to BUS, write goes to DATA.
  - DATA: 4 bytes into wdata, same order, then BUS.
  - BUS: m_req_o=1, m_we_o=(cmd==write), addr/data stable. Held until m_gnt_i=1. In the grant cycle, read latches m_data_i. Next cycle m_req_o=0, go to RSP.
  - RSP: write sends 0x06; read sends 4 data bytes LSB-byte first. Then IDLE, busy_o=0, cpu_hold_o=0 on the cycle after the last stop bit ends.
  - NAK: send 0x15, then IDLE with the same deassertion.
- TX engine:
  - 1 start, 8 data LSB-first, 1 stop, each DIV cycles.
  - Accepts a byte only when idle. Back-to-back bytes have no extra idle gap.
- Errors and timeout:
  - Any frame_err in CMD/ADDR/DATA gives NAK. frame_err in IDLE is ignored.
  - Inter-byte timeout in CMD/ADDR/DATA returns silently to IDLE; hold and busy drop.
  - No timeout in BUS: waits for grant indefinitely.
- RX during BUS/RSP/NAK: bytes are received but discarded.
- cpu_hold_o is asserted from the cycle after 0xA5 is accepted through frame end.

Decomposition:
- Shared package/defines:
  - SYNC=0xA5, CMD_WR=0x01, CMD_RD=0x02, ACK=0x06, NAK=0x15
  - FSM state encodings
  - DIV computation macro
- Natural sub-module: uart_byte_rx (synchronizer, bit timing, byte_valid/frame_err). TX serializer and frame FSM stay in the top.

Test Plan:
- Write frame A5 01 00 00 00 10 EF BE AD DE at BAUD, gnt tied 1 -> one req cycle with we=1, addr=0x10000000, data=0xDEADBEEF; TX returns 0x06; hold high throughout, low after.
- Read frame A5 02 04 00 00 20, m_data_i=0x12345678 in a grant delayed 5 cycles -> req held 6 cycles, we=0; TX bytes 78 56 34 12.
- Bad cmd A5 07 -> TX 0x15, no req; misaligned addr A5 01 02 00 00 00 -> 0x15 after the 4th addr byte, no req.
- Corrupt stop bit on the 3rd address byte -> NAK 0x15, no bus activity; a following valid frame executes normally.
- Send A5 01 then stop for >20 bit periods -> silent return to IDLE, cpu_hold_o/busy_o fall, no TX.
- Assert rst during DATA byte 2 -> all outputs at reset values next cycle; a subsequent full write frame succeeds.

Source files
------------

// File: rtl/uart_bus_loader_pkg.sv
// rtl/uart_bus_loader_pkg.sv - shared constants, state encodings and bit-period helper for the UART bus loader
package uart_bus_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WR    = 8'h01;
    localparam logic [7:0] CMD_RD    = 8'h02;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_RSP,
        ST_NAK
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - UART byte receiver: 2-FF synchronizer, mid-bit sampling, byte_valid / frame_err pulses
module uart_byte_rx
    import uart_bus_loader_pkg::*;
#(
    parameter int unsigned DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy
);
    localparam logic [15:0] FULL_M1 = 16'(DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);

    rx_state_t   r_state;
    rx_state_t   w_state_next;
    logic [1:0]  r_sync;
    logic        r_line_d;
    logic [15:0] r_cnt;
    logic [2:0]  r_bitn;
    logic [7:0]  r_shift;
    logic        r_valid;
    logic        r_ferr;
    logic        w_line;
    logic        w_fall;
    logic        w_tick;

    assign w_line = r_sync[1];
    assign w_fall = r_line_d & ~w_line;
    // START waits half a bit to land in the middle of the start bit; later ticks are a full bit apart
    assign w_tick = (r_state == RX_START) ? (r_cnt == HALF_M1)
                                          : ((r_state != RX_IDLE) && (r_cnt == FULL_M1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= RX_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RX_IDLE:  if (w_fall) w_state_next = RX_START;
            RX_START: if (w_tick) w_state_next = w_line ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_tick && r_bitn == 3'd7) w_state_next = RX_STOP;
            RX_STOP:  if (w_tick) w_state_next = RX_IDLE;
            default:  w_state_next = RX_IDLE;
        endcase
    end

    always_comb begin
        o_busy      = (r_state != RX_IDLE);
        o_byte      = r_shift;
        o_valid     = r_valid;
        o_frame_err = r_ferr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= 2'b11;
            r_line_d <= 1'b1;
            r_cnt    <= 16'd0;
            r_bitn   <= 3'd0;
            r_shift  <= 8'd0;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], i_rx};
            r_line_d <= w_line;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;
            if (r_state == RX_IDLE || w_tick) r_cnt <= 16'd0;
            else                              r_cnt <= r_cnt + 16'd1;
            if (r_state == RX_IDLE) begin
                r_bitn <= 3'd0;
            end else if (w_tick && r_state == RX_DATA) begin
                r_bitn  <= r_bitn + 3'd1;
                r_shift <= {w_line, r_shift[7:1]};
            end
            if (w_tick && r_state == RX_STOP) begin
                r_valid <= w_line;
                r_ferr  <= ~w_line;
            end
        end
    end

endmodule

// File: rtl/uart_bus_loader.sv
// rtl/uart_bus_loader.sv - UART command frames to single-word bus reads/writes, with ACK/NAK/read-data replies
module uart_bus_loader
    import uart_bus_loader_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_pin,
    output logic        tx_pin,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_data_o,
    input  logic [31:0] m_data_i,
    output logic        m_req_o,
    output logic        m_we_o,
    input  logic        m_gnt_i,
    output logic        cpu_hold_o,
    output logic        busy_o
);
    localparam int unsigned DIV    = calc_div(CLK_HZ, BAUD);
    localparam logic [15:0] DIV_M1 = 16'(DIV - 1);
    localparam logic [31:0] TO_M1  = 32'(TIMEOUT_BITS * DIV - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_cmd;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [1:0]  r_bcnt;
    logic [2:0]  r_tx_idx;
    logic [31:0] r_to_cnt;
    logic [9:0]  r_tx_shift;
    logic        r_tx_busy;
    logic [15:0] r_tx_cnt;
    logic [3:0]  r_tx_bitn;
    logic [7:0]  w_rx_byte;
    logic        w_rx_valid;
    logic        w_rx_ferr;
    logic        w_rx_busy;
    logic        w_is_wr;
    logic        w_in_frame;
    logic        w_timeout;
    logic        w_tx_done;
    logic        w_tx_ready;
    logic        w_tx_start;
    logic [7:0]  w_tx_byte;
    logic [2:0]  w_tx_count;

    uart_byte_rx #(.DIV(DIV)) u_rx (
        .clk         (clk),
        .rst         (rst),
        .i_rx        (rx_pin),
        .o_byte      (w_rx_byte),
        .o_valid     (w_rx_valid),
        .o_frame_err (w_rx_ferr),
        .o_busy      (w_rx_busy)
    );

    assign w_is_wr    = (r_cmd == CMD_WR);
    assign w_in_frame = (r_state == ST_CMD) || (r_state == ST_ADDR) || (r_state == ST_DATA);
    assign w_timeout  = w_in_frame && (r_to_cnt == TO_M1);
    // Ready during the last stop-bit cycle so queued reply bytes leave back-to-back
    assign w_tx_done  = r_tx_busy && (r_tx_cnt == DIV_M1) && (r_tx_bitn == 4'd9);
    assign w_tx_ready = !r_tx_busy || w_tx_done;
    assign w_tx_count = (r_state == ST_RSP && !w_is_wr) ? 3'd4 : 3'd1;
    assign m_addr_o   = r_addr;
    assign m_data_o   = r_wdata;
    assign tx_pin     = r_tx_shift[0];

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_rx_valid && w_rx_byte == SYNC_BYTE) w_state_next = ST_CMD;
            ST_CMD: begin
                if (w_rx_ferr)       w_state_next = ST_NAK;
                else if (w_rx_valid) w_state_next = (w_rx_byte == CMD_WR || w_rx_byte == CMD_RD) ? ST_ADDR : ST_NAK;
                else if (w_timeout)  w_state_next = ST_IDLE;
            end
            ST_ADDR: begin
                if (w_rx_ferr) w_state_next = ST_NAK;
                else if (w_rx_valid && r_bcnt == 2'd3) begin
                    if (r_addr[1:0] != 2'b00) w_state_next = ST_NAK;
                    else                      w_state_next = w_is_wr ? ST_DATA : ST_BUS;
                end else if (w_timeout) w_state_next = ST_IDLE;
            end
            ST_DATA: begin
                if (w_rx_ferr)                           w_state_next = ST_NAK;
                else if (w_rx_valid && r_bcnt == 2'd3)   w_state_next = ST_BUS;
                else if (w_timeout)                      w_state_next = ST_IDLE;
            end
            ST_BUS:  if (m_gnt_i) w_state_next = ST_RSP;
            ST_RSP, ST_NAK: if (r_tx_idx == w_tx_count && w_tx_done) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        m_req_o    = (r_state == ST_BUS);
        m_we_o     = (r_state == ST_BUS) && w_is_wr;
        busy_o     = (r_state != ST_IDLE);
        cpu_hold_o = (r_state != ST_IDLE);
        w_tx_start = ((r_state == ST_RSP) || (r_state == ST_NAK)) && (r_tx_idx < w_tx_count) && w_tx_ready;
        w_tx_byte  = 8'h00;
        if (r_state == ST_NAK)     w_tx_byte = NAK_BYTE;
        else if (w_is_wr)          w_tx_byte = ACK_BYTE;
        else                       w_tx_byte = r_rdata[{r_tx_idx[1:0], 3'b000} +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd    <= 8'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_bcnt   <= 2'd0;
            r_tx_idx <= 3'd0;
            r_to_cnt <= 32'd0;
        end else begin
            r_to_cnt <= (w_in_frame && !w_rx_busy && !w_rx_valid) ? r_to_cnt + 32'd1 : 32'd0;
            if (r_state != w_state_next)                                      r_bcnt <= 2'd0;
            else if (w_rx_valid && (r_state == ST_ADDR || r_state == ST_DATA)) r_bcnt <= r_bcnt + 2'd1;
            if (w_rx_valid && r_state == ST_CMD)  r_cmd <= w_rx_byte;
            if (w_rx_valid && r_state == ST_ADDR) r_addr[{r_bcnt, 3'b000} +: 8] <= w_rx_byte;
            if (w_rx_valid && r_state == ST_DATA) r_wdata[{r_bcnt, 3'b000} +: 8] <= w_rx_byte;
            if (r_state == ST_BUS && m_gnt_i && !w_is_wr) r_rdata <= m_data_i;
            if (r_state == ST_RSP || r_state == ST_NAK) begin
                if (w_tx_start) r_tx_idx <= r_tx_idx + 3'd1;
            end else begin
                r_tx_idx <= 3'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_shift <= 10'h3FF;
            r_tx_busy  <= 1'b0;
            r_tx_cnt   <= 16'd0;
            r_tx_bitn  <= 4'd0;
        end else if (w_tx_start) begin
            r_tx_shift <= {1'b1, w_tx_byte, 1'b0};
            r_tx_busy  <= 1'b1;
            r_tx_cnt   <= 16'd0;
            r_tx_bitn  <= 4'd0;
        end else if (r_tx_busy) begin
            if (r_tx_cnt == DIV_M1) begin
                r_tx_cnt   <= 16'd0;
                r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                if (r_tx_bitn == 4'd9) r_tx_busy <= 1'b0;
                else                   r_tx_bitn <= r_tx_bitn + 4'd1;
            end else begin
                r_tx_cnt <= r_tx_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_bus_loader.sv
// tb/tb_uart_bus_loader.sv - scoreboard bench: UART frames in, bus transactions and reply bytes checked
module tb_uart_bus_loader;
    localparam int CLK_HZ  = 1600;
    localparam int BAUD    = 100;
    localparam int DIV     = CLK_HZ / BAUD;
    localparam int TO_BITS = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_pin = 1'b1;
    logic        tx_pin;
    logic [31:0] m_addr_o;
    logic [31:0] m_data_o;
    logic [31:0] m_data_i = 32'd0;
    logic        m_req_o;
    logic        m_we_o;
    logic        m_gnt_i = 1'b0;
    logic        cpu_hold_o;
    logic        busy_o;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_t;

    bus_t       bus_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] frm[$];
    int         total = 0;
    int         bad = 0;
    bit         gnt_tied = 1'b1;
    int         gnt_delay = 0;
    int         req_cnt = 0;
    int         req_cycles = 0;

    always #5 clk = ~clk;

    uart_bus_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_BITS(TO_BITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_pin     (rx_pin),
        .tx_pin     (tx_pin),
        .m_addr_o   (m_addr_o),
        .m_data_o   (m_data_o),
        .m_data_i   (m_data_i),
        .m_req_o    (m_req_o),
        .m_we_o     (m_we_o),
        .m_gnt_i    (m_gnt_i),
        .cpu_hold_o (cpu_hold_o),
        .busy_o     (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Grant driver and bus scoreboard: grant is raised in the cycle the transaction completes
    always @(negedge clk) begin
        bus_t e;
        if (m_req_o) begin
            req_cycles++;
            if (gnt_tied || req_cnt == gnt_delay) begin
                m_gnt_i = 1'b1;
                req_cnt = 0;
                if (bus_q.size() == 0) begin
                    chk("bus_unexp", bus_q.size(), 1);
                end else begin
                    e = bus_q.pop_front();
                    chk("bus_we", m_we_o, e.we);
                    chk("bus_addr", m_addr_o, e.addr);
                    if (e.we) chk("bus_wdata", m_data_o, e.data);
                end
            end else begin
                m_gnt_i = 1'b0;
                req_cnt++;
            end
        end else begin
            m_gnt_i = gnt_tied;
            req_cnt = 0;
        end
    end

    initial begin : tx_mon
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx_pin === 1'b0 && !rst) begin
                repeat (DIV / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = tx_pin;
                end
                repeat (DIV) @(negedge clk);
                chk("tx_stop", tx_pin, 1);
                if (tx_q.size() == 0) chk("tx_unexp", tx_q.size(), 1);
                else                  chk("tx_byte", b, tx_q.pop_front());
            end
        end
    end

    task automatic bits(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rx_pin = 1'b0;
        bits(DIV);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            bits(DIV);
        end
        rx_pin = ~bad_stop;
        bits(DIV);
        rx_pin = 1'b1;
        if (bad_stop) bits(DIV);
    endtask

    task automatic send_frm();
        foreach (frm[i]) send_byte(frm[i], 1'b0);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, busy_o, 0);
        repeat (2 * DIV) @(negedge clk);
    endtask

    task automatic check_end(input string tag, input int exp_req);
        chk({tag, "_hold"}, cpu_hold_o, 0);
        chk({tag, "_req"}, req_cycles, exp_req);
        chk({tag, "_txq"}, tx_q.size(), 0);
        chk({tag, "_busq"}, bus_q.size(), 0);
        req_cycles = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_tx"}, tx_pin, 1);
        chk({tag, "_req"}, m_req_o, 0);
        chk({tag, "_we"}, m_we_o, 0);
        chk({tag, "_addr"}, m_addr_o, 0);
        chk({tag, "_data"}, m_data_o, 0);
        chk({tag, "_hold"}, cpu_hold_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk);
        #1 rst = 1'b0;
        bits(5);

        gnt_tied = 1'b1;
        bus_q.push_back('{we: 1'b1, addr: 32'h1000_0000, data: 32'hDEAD_BEEF});
        tx_q.push_back(8'h06);
        frm = {8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_frm();
        chk("wr_hold_mid", cpu_hold_o, 1);
        chk("wr_busy_mid", busy_o, 1);
        wait_idle("wr_idle");
        check_end("wr", 1);

        gnt_tied  = 1'b0;
        gnt_delay = 5;
        m_data_i  = 32'h1234_5678;
        bus_q.push_back('{we: 1'b0, addr: 32'h2000_0004, data: 32'h0});
        tx_q = {8'h78, 8'h56, 8'h34, 8'h12};
        frm = {8'hA5, 8'h02, 8'h04, 8'h00, 8'h00, 8'h20};
        send_frm();
        wait_idle("rd_idle");
        check_end("rd", 6);
        gnt_tied = 1'b1;

        tx_q.push_back(8'h15);
        frm = {8'hA5, 8'h07};
        send_frm();
        wait_idle("badcmd_idle");
        check_end("badcmd", 0);

        tx_q.push_back(8'h15);
        frm = {8'hA5, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00};
        send_frm();
        wait_idle("misal_idle");
        check_end("misal", 0);

        tx_q.push_back(8'h15);
        frm = {8'hA5, 8'h01, 8'h00, 8'h00};
        send_frm();
        send_byte(8'h00, 1'b1);
        wait_idle("ferr_idle");
        check_end("ferr", 0);

        bus_q.push_back('{we: 1'b1, addr: 32'h0000_0008, data: 32'h1122_3344});
        tx_q.push_back(8'h06);
        frm = {8'hA5, 8'h01, 8'h08, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
        send_frm();
        wait_idle("wr2_idle");
        check_end("wr2", 1);

        frm = {8'hA5, 8'h01};
        send_frm();
        chk("to_hold_mid", cpu_hold_o, 1);
        bits((TO_BITS + 5) * DIV);
        chk("to_busy", busy_o, 0);
        check_end("to", 0);

        frm = {8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h30, 8'h11};
        send_frm();
        rx_pin = 1'b0;
        bits(DIV);
        rx_pin = 1'b1;
        bits(2 * DIV);
        rst = 1'b1;
        rx_pin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("mrst");
        bits(2);
        rst = 1'b0;
        bits(2 * DIV);
        bus_q.push_back('{we: 1'b1, addr: 32'h0000_0040, data: 32'hCAFE_F00D});
        tx_q.push_back(8'h06);
        frm = {8'hA5, 8'h01, 8'h40, 8'h00, 8'h00, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
        send_frm();
        wait_idle("wr3_idle");
        check_end("wr3", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
